// File: rtl/fetch_line_responder.sv
// Fetch-side line responder: single 4-word line buffer, 1-cycle hits, 4-beat word fill on a miss.
// Optional build macro FETCH_CRITICAL_WORD_FIRST_EN starts each fill at the requested word and wraps.
module fetch_line_responder #(
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                flush_i,
  input  logic                req_valid_i,
  input  logic [ADDR_W-1:0]   req_pc_i,
  output logic                req_ready_o,
  output logic                resp_valid_o,
  output logic [ADDR_W-1:0]   resp_pc_o,
  output logic [4*INSN_W-1:0] resp_idata_o,
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic                mem_ack_i,
  input  logic [INSN_W-1:0]   mem_rdata_i
);

  localparam int TAG_W  = ADDR_W - 4;
  localparam int LINE_W = 4 * INSN_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_line_valid;
  logic [TAG_W-1:0]    r_tag;
  logic [1:0]          r_beat;
  logic [1:0]          r_start;
  logic [ADDR_W-1:0]   r_pc;
  logic [LINE_W-1:0]   r_line;
  logic [LINE_W-1:0]   r_resp_idata;

  logic                w_accept;
  logic                w_hit;
  logic                w_ack;
  logic [1:0]          w_widx;
  logic [1:0]          w_start_next;
  logic [LINE_W-1:0]   w_line_wr;
  logic                w_unused_pc;

`ifdef FETCH_CRITICAL_WORD_FIRST_EN
  assign w_start_next = req_pc_i[3:2];
`else
  assign w_start_next = 2'b00;
`endif

  assign w_unused_pc = ^req_pc_i[3:0];

  assign req_ready_o  = reset_i && (r_state == S_IDLE) && !flush_i;
  assign w_accept     = req_valid_i && req_ready_o;
  assign w_hit        = r_line_valid && (r_tag == req_pc_i[ADDR_W-1:4]);
  assign w_widx       = r_beat + r_start;
  // Flush withdraws the memory request in the same cycle so a late ack cannot land.
  assign mem_req_o    = (r_state == S_FILL) && !flush_i;
  assign w_ack        = mem_ack_i && mem_req_o;
  assign mem_addr_o   = (r_state == S_FILL) ? {r_tag, w_widx, 2'b00} : {ADDR_W{1'b0}};
  assign resp_valid_o = (r_state == S_RESP) && !flush_i;
  assign resp_pc_o    = r_pc;
  assign resp_idata_o = r_resp_idata;

  // Line buffer image with the incoming beat merged into its word slot.
  always_comb begin
    w_line_wr = r_line;
    for (int k = 0; k < 4; k++) begin
      if (w_widx == 2'(k)) begin
        w_line_wr[k*INSN_W +: INSN_W] = mem_rdata_i;
      end else begin
        w_line_wr[k*INSN_W +: INSN_W] = r_line[k*INSN_W +: INSN_W];
      end
    end
  end

  // Control FSM, line buffer and response registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state      <= S_IDLE;
      r_line_valid <= 1'b0;
      r_tag        <= {TAG_W{1'b0}};
      r_beat       <= 2'b00;
      r_start      <= 2'b00;
      r_pc         <= {ADDR_W{1'b0}};
      r_line       <= {LINE_W{1'b0}};
      r_resp_idata <= {LINE_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pc <= req_pc_i;
            if (w_hit) begin
              r_resp_idata <= r_line;
              r_state      <= S_RESP;
            end else begin
              r_line_valid <= 1'b0;
              r_tag        <= req_pc_i[ADDR_W-1:4];
              r_beat       <= 2'b00;
              r_start      <= w_start_next;
              r_state      <= S_FILL;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FILL: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else if (w_ack) begin
            r_line <= w_line_wr;
            r_beat <= r_beat + 2'd1;
            if (r_beat == 2'd3) begin
              r_line_valid <= 1'b1;
              r_resp_idata <= w_line_wr;
              r_state      <= S_RESP;
            end else begin
              r_state <= S_FILL;
            end
          end else begin
            r_state <= S_FILL;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      if (flush_i) begin
        r_line_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_line_responder.sv
// Scoreboard bench for fetch_line_responder: directed scenarios plus random requests against a line-cache model.
module tb_fetch_line_responder;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         req_valid = 1'b0;
  logic [31:0]  req_pc = 32'h0;
  logic         req_ready;
  logic         resp_valid;
  logic [31:0]  resp_pc;
  logic [127:0] resp_idata;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic [31:0]  mem_rdata = 32'h0;

  fetch_line_responder #(.ADDR_W(32), .INSN_W(32)) dut (
    .clk_i(clk), .reset_i(reset_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_pc_i(req_pc), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_pc_o(resp_pc), .resp_idata_o(resp_idata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  pc;
    logic [127:0] line;
    int           cyc;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] exp_addr[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mem_wait = 0;
  bit          model_valid = 1'b0;
  logic [27:0] model_tag = 28'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Backing memory contents: distinct word per address, 0xA0.. at 0x1000..
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return ((a - 32'h1000) >> 2) + 32'hA0;
  endfunction

  function automatic logic [127:0] model_line(input logic [27:0] tag);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = mem_data({tag, 4'h0} + 32'(4 * k));
    return l;
  endfunction

  // Memory responder: acks after mem_wait idle cycles, checks address order and stability.
  initial begin : memory
    int cnt;
    logic [31:0] held;
    cnt = 0;
    held = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        if (cnt == 0) held = mem_addr;
        else chk("mem_addr_stable", mem_addr, held);
        if (cnt >= mem_wait) begin
          mem_ack = 1'b1;
          mem_rdata = mem_data(mem_addr);
          cnt = 0;
          if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_req_unexpected: got addr %0h expected no request", mem_addr);
          end else begin
            chk("mem_addr", mem_addr, exp_addr.pop_front());
          end
        end else begin
          mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every response pulse.
  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got pc %0h expected no response", resp_pc);
        end else begin
          e = exp_q.pop_front();
          chk("resp_pc", resp_pc, e.pc);
          chk("resp_line", resp_idata, e.line);
          chk("resp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      fail_now("resp_timeout");
      exp_q.delete();
    end
  endtask

  task automatic do_req(input logic [31:0] pc, input int wait_n, input bit expect_resp);
    int guard;
    int a;
    int lat;
    bit hit;
    logic [1:0] st;
    resp_t e;
    drain();
    mem_wait = wait_n;
    @(negedge clk);
    req_valid = 1'b1;
    req_pc = pc;
    #1;
    guard = 0;
    while (!req_ready && guard < 500) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!req_ready) begin
      fail_now("req_ready_timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    a = cyc;
    hit = model_valid && (model_tag == pc[31:4]);
    if (!hit) begin
`ifdef FETCH_CRITICAL_WORD_FIRST_EN
      st = pc[3:2];
`else
      st = 2'b00;
`endif
      for (int k = 0; k < 4; k++) exp_addr.push_back({pc[31:4], 2'(st + 2'(k)), 2'b00});
    end
    lat = hit ? 1 : 4 * (wait_n + 1) + 1;
    if (expect_resp) begin
      e.pc = pc;
      e.line = model_line(pc[31:4]);
      e.cyc = a + lat - 1;
      exp_q.push_back(e);
      model_valid = 1'b1;
      model_tag = pc[31:4];
    end else begin
      model_valid = 1'b0;
    end
  endtask

  initial begin : stim
    logic [27:0] tags[4];
    tags[0] = 28'h0000100;
    tags[1] = 28'h0000200;
    tags[2] = 28'h0000300;
    tags[3] = 28'h00004AB;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_pc", resp_pc, 32'h0);
    chk("rst_resp_idata", resp_idata, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_req_ready", req_ready, 1'b1);

    do_req(32'h0000_1008, 0, 1'b1);
    do_req(32'h0000_100C, 0, 1'b1);
    do_req(32'h0000_2000, 2, 1'b1);
    do_req(32'h0000_1004, 0, 1'b1);
    do_req(32'h0000_1000, 0, 1'b1);

    // Flush after the second ack of a fill.
    do_req(32'h0000_2004, 0, 1'b0);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    #2;
    chk("flush_mem_req", mem_req, 1'b0);
    chk("flush_resp_valid", resp_valid, 1'b0);
    chk("flush_beats_left", exp_addr.size(), 2);
    @(negedge clk);
    flush = 1'b0;
    #2;
    chk("flush_ready_after", req_ready, 1'b1);
    exp_addr.delete();
    do_req(32'h0000_2004, 0, 1'b1);

    // Flush together with a request in IDLE.
    drain();
    @(negedge clk);
    flush = 1'b1;
    req_valid = 1'b1;
    req_pc = 32'h0000_2008;
    #1;
    chk("flush_req_ready", req_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    model_valid = 1'b0;
    #1;
    chk("flush_req_no_fill", mem_req, 1'b0);
    do_req(32'h0000_2008, 1, 1'b1);

    // Reset pulled low mid-fill.
    do_req(32'h0000_3000, 2, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 1'b0);
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b0);
    chk("midrst_resp_idata", resp_idata, 128'h0);
    exp_addr.delete();
    @(negedge clk);
    reset_n = 1'b1;
    model_valid = 1'b0;
    do_req(32'h0000_3004, 0, 1'b1);
    do_req(32'h0000_1008, 0, 1'b1);
    do_req(32'h0000_3008, 0, 1'b1);
    do_req(32'h0000_300C, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      do_req({tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15))}, $urandom_range(0, 3), 1'b1);
    end

    drain();
    repeat (4) @(negedge clk);
    chk("mem_addr_all_issued", exp_addr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_line_responder.md
Name: fetch_line_responder

Overview:
- Memory-side responder for the instruction fetch stage.
- Accepts a fetch request carrying a PC and returns the full 4-instruction aligned line (128 bits) that the fetch stage selects from using pc[3:2].
- Holds a single-line buffer. Hits answer in 1 cycle. Misses fill the line by issuing four 32-bit word reads to a backing instruction memory, then respond.
- Sits between the IF stage and the instruction memory port.

Parameters:
- ADDR_W, 32, PC / memory address width.
- INSN_W, 32, instruction word width; line width is 4*INSN_W.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  invalidate line buffer and abort any fill.
- req_valid_i  in  1  fetch request valid.
- req_pc_i  in  ADDR_W  fetch PC; bits [1:0] are ignored.
- req_ready_o  out  1  request can be accepted this cycle.
- resp_valid_o  out  1  one-cycle pulse: line data valid.
- resp_pc_o  out  ADDR_W  PC of the request being answered.
- resp_idata_o  out  4*INSN_W  line; word k sits at [k*INSN_W +: INSN_W] for address base+4k.
- mem_req_o  out  1  word read request to instruction memory.
- mem_addr_o  out  ADDR_W  word address, low 2 bits always 0.
- mem_ack_i  in  1  word read complete; mem_rdata_i valid this cycle.
- mem_rdata_i  in  INSN_W  read data.

Behaviour:
- Reset (reset_i=0, async):
  - State IDLE, line_valid=0, beat counter 0.
  - All outputs 0 except req_ready_o, which is 0 while reset is asserted and 1 in the first cycle after release.
- Line tag is pc[ADDR_W-1:4]. Hit = line_valid && stored tag == req_pc_i[ADDR_W-1:4].
- States: IDLE, FILL, RESP.
- IDLE:
  - req_ready_o = !flush_i.
  - Accept = req_valid_i && req_ready_o; on accept, latch req_pc_i.
  - On a hit: go to RESP.
  - On a miss: line_valid<=0, store the new tag, beat<=0, go to FILL.
- FILL:
  - req_ready_o=0, mem_req_o=1.
  - mem_addr_o = {tag, beat[1:0], 2'b00}.
  - mem_addr_o is held stable until mem_ack_i.
  - mem_ack_i is sampled only while mem_req_o=1.
  - Each ack writes mem_rdata_i into line word beat and increments beat.
  - The ack on beat 3 sets line_valid=1 and goes to RESP. mem_req_o drops in RESP.
  - Memory may ack in the same cycle mem_req_o rises (0-wait memory), so a minimum fill is 4 cycles.
- RESP:
  - resp_valid_o=1 for exactly one cycle, with resp_pc_o = latched PC and resp_idata_o = line buffer. Then go to IDLE.
  - The consumer cannot back-pressure; the response is lost if ignored.
- Latency from accept edge to resp_valid_o:
  - Hit: 1 cycle.
  - Miss: (sum of the 4 beat latencies) + 1.
- resp_idata_o holds the last line between pulses and is 0 after reset.
- flush_i:
  - Clears line_valid in any state.
  - In FILL: drops mem_req_o the same cycle (combinational gate) and goes to IDLE with no response. An ack in that cycle is ignored.
  - In RESP: the pulse is suppressed and the state goes to IDLE.
  - Flush together with req_valid_i in IDLE: flush wins, request not accepted.
- The backing memory must tolerate withdrawal of mem_req_o without an ack.
- Back-to-back hits: one response every 2 cycles (IDLE->RESP->IDLE).
- Beat counter wraps mod 4.

Optional Feature:
- Macro: FETCH_CRITICAL_WORD_FIRST_EN.
- When defined:
  - A miss starts the fill at word req_pc_i[3:2] and wraps 3->0 until all 4 words are filled.
  - mem_addr_o word index = (start + beat) mod 4.
  - resp_idata_o word placement is unchanged (word k always at base+4k).
- When undefined: the fill always starts at word 0. Response timing and content are identical in both builds for a given memory latency.

Test Plan:
- Reset, then req pc=0x0000_1008 (miss), 0-wait memory returning 0xA0,0xA1,0xA2,0xA3 -> mem_addr_o 0x1000,0x1004,0x1008,0x100C; resp_valid_o pulse with resp_idata_o={0xA3,0xA2,0xA1,0xA0}, resp_pc_o=0x1008, 5 cycles after accept.
- Follow-up req pc=0x0000_100C -> hit, no mem_req_o, resp_valid_o 1 cycle after accept with the same line.
- Req pc=0x0000_2000 with memory acking every 3rd cycle -> mem_addr_o stays stable while waiting, 4 fills, response once the 4th ack lands; tag switches so pc=0x1004 then misses.
- flush_i asserted after the 2nd ack of a fill -> mem_req_o drops the same cycle, no resp_valid_o, req_ready_o=1 next cycle; re-request of the same pc refills from word 0.
- flush_i and req_valid_i high together in IDLE -> req_ready_o=0, not accepted; reset_i pulled low mid-FILL -> mem_req_o=0 and resp_valid_o=0 immediately, line invalid.
- With FETCH_CRITICAL_WORD_FIRST_EN, req pc=0x3008 -> mem_addr_o 0x3008,0x300C,0x3000,0x3004; resp_idata_o ordering identical to the non-macro build.
